pre_equ_24_27_sched: RTL and testbench

Frame-level scheduler for the `pre_equ_24_27` diagonal R/B pre-estimation datapath. It sits between the 3x3 window builder and the datapath. It accepts one neighbourhood window per handshake and tracks raster position. It fires the datapath only at interior sites of the configured Bayer phase, carries the datapath's fixed latency, and buffers results in a small FIFO so that downstream backpressure never loses a result.

---
 rtl/cfa_pkg.sv | 16 +
 rtl/pre_equ_out_fifo.sv | 55 +++++
 rtl/pre_equ_24_27_sched.sv | 214 +++++++++++++++++++++
 tb/tb_pre_equ_24_27_sched.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfa_pkg.sv
// Shared constants and scheduler FSM state type for the pre_equ_24_27 R/B pre-estimation slice.
package cfa_pkg;

    localparam int DW_DEF    = 12;
    localparam int OW_DEF    = 13;
    localparam int CW_DEF    = 12;
    localparam int MIN_FRAME = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/pre_equ_out_fifo.sv
// Synchronous result FIFO for the scheduler; DEPTH must be a power of two.
module pre_equ_out_fifo #(
    parameter  int W     = 38,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [W-1:0]    push_data_i,
    input  logic            pop_i,
    output logic [W-1:0]    head_o,
    output logic            empty_o,
    output logic [CNTW-1:0] count_o
);

    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [CNTW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push_i && (count_q != FULL);
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the count/pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/pre_equ_24_27_sched.sv
// Frame scheduler for the pre_equ_24_27 diagonal R/B datapath: raster tracking, phase-gated issue, credit-limited output FIFO.
// Optional feature: define PRE_EQU_BORDER_PASS_EN to pass phase-matching border sites through as zero results.
module pre_equ_24_27_sched
    import cfa_pkg::*;
#(
    parameter int OW         = OW_DEF,
    parameter int CW         = CW_DEF,
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [CW-1:0]  width,
    input  logic [CW-1:0]  height,
    input  logic [1:0]     phase,
    input  logic           win_valid,
    output logic           win_ready,
    output logic           dp_en,
    input  logic [OW-1:0]  dp_rb,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OW-1:0]  out_rb,
    output logic [CW-1:0]  out_x,
    output logic [CW-1:0]  out_y,
    output logic           out_border,
    output logic           busy,
    output logic           done,
    output logic           cfg_err,
    output sched_state_t   dbg_state
);

    localparam int               CNTW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNTW:0]    CREDITS = (CNTW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]    MIN_SZ  = CW'(MIN_FRAME);

    typedef struct packed {
        logic [OW-1:0] rb;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          border;
    } entry_t;

    sched_state_t  state_q, state_d;
    logic [CW-1:0] width_q, width_d, height_q, height_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [1:0]    phase_q, phase_d;
    logic          err_q, err_d;

    logic          tag_v_q [LAT];
    logic [CW-1:0] tag_x_q [LAT];
    logic [CW-1:0] tag_y_q [LAT];
    logic          tag_b_q [LAT];

    logic            accept, interior, phase_hit, last_win;
    logic            issue_dp, issue_border;
    logic [CNTW-1:0] inflight, fifo_count;
    logic            fifo_empty;
    entry_t          push_entry, head;

    // Handshakes: a window moves when win_valid && win_ready; a result moves when
    // out_valid && out_ready. Both sides hold their offer until it is taken.
    assign win_ready = (state_q == ST_RUN)
                     && (({1'b0, fifo_count} + {1'b0, inflight}) < CREDITS);
    assign accept    = win_valid && win_ready;
    assign interior  = (x_q != '0) && (x_q <= width_q - CW'(2))
                     && (y_q != '0) && (y_q <= height_q - CW'(2));
    assign phase_hit = ({y_q[0], x_q[0]} == phase_q);
    assign last_win  = accept && (x_q == width_q - CW'(1)) && (y_q == height_q - CW'(1));
    assign issue_dp  = accept && interior && phase_hit;

`ifdef PRE_EQU_BORDER_PASS_EN
    assign issue_border = accept && !interior && phase_hit;
`else
    assign issue_border = 1'b0;
`endif

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + CNTW'(tag_v_q[i]);
    end

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        height_d = height_q;
        phase_d  = phase_q;
        err_d    = err_q;
        x_d      = x_q;
        y_d      = y_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    width_d  = width;
                    height_d = height;
                    phase_d  = phase;
                    x_d      = '0;
                    y_d      = '0;
                    if (width >= MIN_SZ && height >= MIN_SZ) begin
                        state_d = ST_RUN;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (x_q == width_q - CW'(1)) begin
                        x_d = '0;
                        y_d = y_q + CW'(1);
                    end else begin
                        x_d = x_q + CW'(1);
                    end
                end
                if (last_win) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (inflight == '0 && fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            width_q  <= '0;
            height_q <= '0;
            phase_q  <= '0;
            err_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            height_q <= height_d;
            phase_q  <= phase_d;
            err_q    <= err_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    // Site tags ride alongside the datapath so each result leaves with its (x,y).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_v_q[i] <= 1'b0;
                tag_x_q[i] <= '0;
                tag_y_q[i] <= '0;
                tag_b_q[i] <= 1'b0;
            end
        end else begin
            tag_v_q[0] <= issue_dp || issue_border;
            tag_x_q[0] <= x_q;
            tag_y_q[0] <= y_q;
            tag_b_q[0] <= issue_border;
            for (int i = 1; i < LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_x_q[i] <= tag_x_q[i-1];
                tag_y_q[i] <= tag_y_q[i-1];
                tag_b_q[i] <= tag_b_q[i-1];
            end
        end
    end

    always_comb begin
        push_entry.rb     = tag_b_q[LAT-1] ? '0 : dp_rb;
        push_entry.x      = tag_x_q[LAT-1];
        push_entry.y      = tag_y_q[LAT-1];
        push_entry.border = tag_b_q[LAT-1];
    end

    pre_equ_out_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (tag_v_q[LAT-1]),
        .push_data_i (push_entry),
        .pop_i       (out_valid && out_ready),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Payload is gated so stale FIFO storage never shows on an idle bus.
    assign out_valid = !fifo_empty;
    assign out_rb    = out_valid ? head.rb : '0;
    assign out_x     = out_valid ? head.x  : '0;
    assign out_y     = out_valid ? head.y  : '0;

`ifdef PRE_EQU_BORDER_PASS_EN
    assign out_border = out_valid && head.border;
`else
    logic unused_border;
    assign unused_border = head.border;
    assign out_border    = 1'b0;
`endif

    assign dp_en     = issue_dp;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign cfg_err   = (state_q == ST_DONE) && err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pre_equ_24_27_sched.sv
// Scoreboard bench for pre_equ_24_27_sched: directed frames, expected results queued, monitor pops and compares.
module tb_pre_equ_24_27_sched;
    import cfa_pkg::*;

    localparam int OW  = 13;
    localparam int CW  = 12;
    localparam int LAT = 1;
    localparam int FD  = 4;
    localparam int EW  = OW + 2 * CW + 1;

`ifdef PRE_EQU_BORDER_PASS_EN
    localparam int S3_DPEN_AT_STALL = 0;
`else
    localparam int S3_DPEN_AT_STALL = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] width;
    logic [CW-1:0] height;
    logic [1:0]    phase;
    logic          win_valid;
    logic          win_ready;
    logic          dp_en;
    logic [OW-1:0] dp_rb = '0;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_rb;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic          out_border;
    logic          busy;
    logic          done;
    logic          cfg_err;
    sched_state_t  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int dp_en_cnt = 0;
    int done_cnt  = 0;
    logic [CW-1:0] frame_w = CW'(4);
    logic [CW-1:0] wx = '0;
    logic [CW-1:0] wy = '0;
    logic [EW-1:0] exp_q[$];

    pre_equ_24_27_sched #(
        .OW (OW), .CW (CW), .LAT (LAT), .FIFO_DEPTH (FD)
    ) dut (
        .clk (clk), .rst (rst), .start (start),
        .width (width), .height (height), .phase (phase),
        .win_valid (win_valid), .win_ready (win_ready),
        .dp_en (dp_en), .dp_rb (dp_rb),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_rb (out_rb), .out_x (out_x), .out_y (out_y), .out_border (out_border),
        .busy (busy), .done (done), .cfg_err (cfg_err), .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- datapath model ----------------
    function automatic logic [OW-1:0] dp_model(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return {1'b1, x[5:0], y[5:0]} ^ 13'h0a5;
    endfunction

    // The window the builder is presenting is (wx,wy); the datapath answers LAT=1 cycle after dp_en.
    always @(posedge clk) begin
        if (dp_en) dp_rb <= dp_model(wx, wy);
        if (rst || start) begin
            wx <= '0;
            wy <= '0;
        end else if (win_valid && win_ready) begin
            if (wx == frame_w - CW'(1)) begin
                wx <= '0;
                wy <= wy + CW'(1);
            end else begin
                wx <= wx + CW'(1);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_site(input int x, input int y, input bit border);
        logic [OW-1:0] rb;
        rb = border ? '0 : dp_model(CW'(x), CW'(y));
        exp_q.push_back({rb, CW'(x), CW'(y), border});
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_out   = '0;

    always @(negedge clk) begin
        logic [EW-1:0] cur;
        logic [EW-1:0] e;
        cur = {out_rb, out_x, out_y, out_border};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(cur), 64'(prev_out));
            end
            if (dp_en) dp_en_cnt++;
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_entry: got x=%0d y=%0d rb=%0h border=%0b, expected no output",
                             out_x, out_y, out_rb, out_border);
                end else begin
                    e = exp_q.pop_front();
                    check("out_entry", 64'(cur), 64'(e));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int w, input int h, input logic [1:0] ph);
        width     = CW'(w);
        height    = CW'(h);
        phase     = ph;
        frame_w   = CW'(w);
        start     = 1'b1;
        win_valid = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit got, output bit err);
        got = 1'b0;
        err = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                err = cfg_err;
                break;
            end
        end
    endtask

    task automatic finish_frame(input string tag, input int dpen_exp, input int dpen_base);
        bit got, err;
        wait_done(600, got, err);
        check({tag, "_done"}, 64'(got), 64'd1);
        check({tag, "_cfg_err"}, 64'(err), 64'd0);
        check({tag, "_dp_en_count"}, 64'(dp_en_cnt - dpen_base), 64'(dpen_exp));
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        win_valid = 1'b0;
        tick();
        @(negedge clk);
        check({tag, "_idle_after"}, 64'(dbg_state), 64'(ST_IDLE));
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic run_4x4_p11(input string tag);
        int base;
        exp_site(1, 1, 0);
`ifdef PRE_EQU_BORDER_PASS_EN
        exp_site(3, 1, 1);
        exp_site(1, 3, 1);
        exp_site(3, 3, 1);
`endif
        out_ready = 1'b1;
        base = dp_en_cnt;
        start_frame(4, 4, 2'b11);
        @(negedge clk);
        check({tag, "_run_state"}, 64'(dbg_state), 64'(ST_RUN));
        check({tag, "_busy"}, 64'(busy), 64'd1);
        finish_frame(tag, 1, base);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
        check({tag, "_outputs"},
              64'({win_ready, dp_en, out_valid, out_border, busy, done, cfg_err}), 64'd0);
        check({tag, "_payload"}, 64'({out_rb, out_x, out_y}), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  base;
        int  dn;
        rst       = 1'b1;
        start     = 1'b0;
        width     = '0;
        height    = '0;
        phase     = '0;
        win_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // 4x4, phase 11: one interior site at (1,1)
        run_4x4_p11("s1");

        // 4x4, phase 00: interior (2,2); border pass adds (0,0),(2,0),(0,2) ahead of it
`ifdef PRE_EQU_BORDER_PASS_EN
        exp_site(0, 0, 1);
        exp_site(2, 0, 1);
        exp_site(0, 2, 1);
`endif
        exp_site(2, 2, 0);
        base = dp_en_cnt;
        start_frame(4, 4, 2'b00);
        finish_frame("s2", 1, base);

        // 8x6, phase 01 with out_ready low: credits must stall the window stream
`ifdef PRE_EQU_BORDER_PASS_EN
        exp_site(1, 0, 1); exp_site(3, 0, 1); exp_site(5, 0, 1); exp_site(7, 0, 1);
`endif
        exp_site(1, 2, 0); exp_site(3, 2, 0); exp_site(5, 2, 0);
`ifdef PRE_EQU_BORDER_PASS_EN
        exp_site(7, 2, 1);
`endif
        exp_site(1, 4, 0); exp_site(3, 4, 0); exp_site(5, 4, 0);
`ifdef PRE_EQU_BORDER_PASS_EN
        exp_site(7, 4, 1);
`endif
        out_ready = 1'b0;
        base = dp_en_cnt;
        start_frame(8, 6, 2'b01);
        repeat (37) tick();
        @(negedge clk);
        check("s3_win_ready_stalled", 64'(win_ready), 64'd0);
        check("s3_out_valid_held", 64'(out_valid), 64'd1);
        check("s3_dp_en_at_stall", 64'(dp_en_cnt - base), 64'(S3_DPEN_AT_STALL));
        check("s3_head_x", 64'(out_x), 64'(exp_q[0][2*CW:CW+1]));
        tick();
        out_ready = 1'b1;
        finish_frame("s3", 6, base);

        // Undersized frame: done and cfg_err together one cycle after start
        base = dp_en_cnt;
        tick();
        width  = CW'(2);
        height = CW'(5);
        start  = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("s4_done", 64'(done), 64'd1);
        check("s4_cfg_err", 64'(cfg_err), 64'd1);
        tick();
        @(negedge clk);
        check("s4_done_pulse", 64'({done, cfg_err}), 64'd0);
        check("s4_state", 64'(dbg_state), 64'(ST_IDLE));
        check("s4_no_dp_en", 64'(dp_en_cnt - base), 64'd0);

        // Reset mid-frame with results queued: everything discarded, no done
        out_ready = 1'b0;
        start_frame(8, 6, 2'b01);
        repeat (20) tick();
        @(negedge clk);
        check("s5_queued", 64'(out_valid), 64'd1);
        dn = done_cnt;
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        @(negedge clk);
        check_all_zero("s5_rst");
        tick();
        rst       = 1'b0;
        win_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("s5_no_done", 64'(done_cnt - dn), 64'd0);
        check("s5_still_idle", 64'({dbg_state, out_valid}), 64'({ST_IDLE, 1'b0}));
        tick();
        run_4x4_p11("s5b");

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
